// File: rtl/nns_db_streamer.sv
// Database source for the sequential nearest-neighbour search: holds DEPTH entries
// and streams slots 0..cnt-1 over valid/ready, framed by a clear pulse and a done pulse.
module nns_db_streamer #(
    parameter int W     = 15,
    parameter int DEPTH = 16,
    parameter int IDXW  = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            wr_en_i,
    input  logic [IDXW-1:0] wr_addr_i,
    input  logic [W-1:0]    wr_data_i,
    output logic            wr_err_o,
    input  logic            start_i,
    input  logic [IDXW:0]   num_ent_i,
    output logic            search_clr_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [W-1:0]    out_data_o,
    output logic [IDXW-1:0] out_idx_o,
    output logic            out_last_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CLR    = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_FIN    = 2'd3;

    localparam logic [IDXW:0] DEPTH_C = (IDXW+1)'(DEPTH);

    logic [1:0]      state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW:0]   cnt_q, cnt_d;
    logic            search_clr_q, busy_q, done_q;
    logic [W-1:0]    mem_q [DEPTH];

    logic streaming;
    logic last_beat;
    logic idle;

    assign idle      = (state_q == S_IDLE);
    assign streaming = (state_q == S_STREAM);
    assign last_beat = ({1'b0, idx_q} == (cnt_q - 1'b1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cnt_d   = (num_ent_i > DEPTH_C) ? DEPTH_C : num_ent_i;
                    idx_d   = '0;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                state_d = (cnt_q == '0) ? S_FIN : S_STREAM;
            end
            S_STREAM: begin
                if (out_ready_i) begin
                    if (last_beat) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pulse outputs are registered from the next state so they line up with CLR/FIN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            search_clr_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            search_clr_q <= (state_d == S_CLR);
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_FIN);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i && idle) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign wr_err_o     = wr_en_i && !idle;
    assign search_clr_o = search_clr_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign out_valid_o  = streaming;
    assign out_data_o   = streaming ? mem_q[idx_q] : '0;
    assign out_idx_o    = streaming ? idx_q : '0;
    assign out_last_o   = streaming && last_beat;

endmodule
